mid_layer_seq: RTL
==================

Name: mid_layer_seq

Overview:
Sequencer for the shared hidden-layer datapath. That datapath has four fp multipliers feeding the calculate_mid adder tree, and it has no valid signalling. One start request evaluates N_MID hidden neurons through this single datapath. The block steps the weight-memory address one neuron per cycle, tracks each issue through the fixed datapath latency with a tagged valid delay line, and writes each neuron's oSUM into the hidden-result buffer. It sits between the top-level network controller (start/done) and the weight memory, the mid_layer datapath and the result buffer.

Parameters:
N_MID, 4, number of hidden neurons evaluated per start (1..256)
MULT_LAT, 5, fp_multiplier latency in cycles
SUM_LAT, 14, calculate_mid latency in cycles (two fp-add levels)
IW, $clog2(N_MID) min 1, neuron index / address width

Ports:
iCLK  in  1  clock; all state on rising edge
iRST_N  in  1  asynchronous active-low reset
iSTART  in  1  start request; sampled only in IDLE
oBUSY  out  1  high while a run is in progress (ISSUE, DRAIN, DONE)
oX_LOAD  out  1  one-cycle pulse; freezes input-vector registers (X0,X1,X2,X12) for the run
oW_REN  out  1  weight-memory read enable
oW_RADDR  out  IW  weight-memory address = neuron index; memory returns V0,V1,V2,V12 one cycle later
iSUM  in  32  oSUM from mid_layer datapath
oRES_WE  out  1  result-buffer write enable
oRES_ADDR  out  IW  result-buffer address = neuron index
oRES_DATA  out  32  result word (registered copy of iSUM)
oDONE  out  1  one-cycle pulse; all N_MID results written

Behaviour:
- Reset (iRST_N=0, async): state=IDLE. oBUSY, oX_LOAD, oW_REN, oRES_WE and oDONE are 0. oW_RADDR, oRES_ADDR and oRES_DATA are 0. Issue counter and every valid delay-line stage are cleared.
- PIPE_LAT = 1 + MULT_LAT + SUM_LAT (default 20). A read issued in cycle c yields a valid iSUM for that index in cycle c+PIPE_LAT.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - iSTART=1 in cycle s: oX_LOAD=1 in cycle s. Next state is ISSUE. Issue counter is set to 0.
  - iSTART=0: stay in IDLE.
- ISSUE: oW_REN=1 and oW_RADDR=counter, so neuron i is issued in cycle s+1+i. The counter increments each cycle. After issuing N_MID-1, go to DRAIN. There are no bubbles, one issue per cycle.
- Delay line: PIPE_LAT stages of {valid, index}. Stage 0 is loaded with {oW_REN, oW_RADDR}.
- Capture: when the last delay-line stage is valid (cycle c+PIPE_LAT), sample iSUM and the index. In the next cycle drive oRES_WE=1, oRES_DATA=sampled iSUM and oRES_ADDR=index. Neuron i is therefore written in cycle s+2+i+PIPE_LAT.
- DRAIN: oW_REN=0. When the write of index N_MID-1 occurs, go to DONE.
- DONE: one cycle, in cycle s+2+N_MID+PIPE_LAT. oDONE=1, then next state is IDLE.
- The earliest next accepted iSTART is in cycle s+3+N_MID+PIPE_LAT.
- oBUSY=1 from s+1 through the DONE cycle inclusive. oBUSY=0 in IDLE, including the accept cycle s.
- iSTART outside IDLE is ignored. It is not queued.
- N_MID=1: ISSUE lasts one cycle, then DRAIN.
- Results are written strictly in index order 0..N_MID-1, each address exactly once per run.
- oRES_WE is 0 in every cycle in which no delay-line output was valid in the previous cycle.
- Reset mid-run: all outputs return to reset values immediately. In-flight delay-line entries are discarded, and no write is emitted after reset release. The next iSTART begins a fresh run from index 0.
- iX values and the weight-memory data path do not pass through this block. It only times them.

Test Plan:
- Defaults, iSTART=1 at cycle 0 → oX_LOAD at cycle 0. oW_REN cycles 1–4 with oW_RADDR 0,1,2,3. oRES_WE cycles 22–25 with oRES_ADDR 0..3. oDONE only at cycle 26. oBUSY cycles 1–26.
- Datapath model returning iSUM=32'h3F800000+index at c+20 → oRES_DATA at cycle 22 is 3F800000 and at cycle 25 is 3F800003. A model off by one cycle must produce a scoreboard mismatch.
- iSTART held high continuously → the second run's oX_LOAD occurs at cycle 27. iSTART pulses at cycles 5 and 26 are ignored; exactly 4 writes occur per run.
- iRST_N low at cycle 10 for 2 cycles → outputs go to 0 asynchronously and no oRES_WE appears afterwards. iSTART at cycle 15 → writes at 37–40 and oDONE at 41.
- N_MID=1, MULT_LAT=1, SUM_LAT=1 (PIPE_LAT=3), start at cycle 0 → oW_REN at cycle 1 only, oRES_WE at cycle 5 with address 0, oDONE at cycle 6.
- Randomized start gaps, 100 runs → each run writes every address 0..N_MID-1 exactly once, in order, and emits one oDONE.

Source files
------------

// File: rtl/mid_layer_seq.sv
// mid_layer_seq: issues N_MID hidden-neuron reads through the shared datapath and writes each oSUM to the result buffer
// Ports:
//   iCLK, iRST_N           clock, asynchronous active-low reset
//   iSTART                 run request, honoured only in IDLE
//   oBUSY                  run in progress (ISSUE, DRAIN, DONE)
//   oX_LOAD                one-cycle pulse that freezes the input-vector registers
//   oW_REN, oW_RADDR       weight-memory read enable / neuron index
//   iSUM                   datapath oSUM, valid PIPE_LAT cycles after a read
//   oRES_WE, oRES_ADDR,    result-buffer write port
//   oRES_DATA
//   oDONE                  one-cycle pulse after the last result is written
module mid_layer_seq #(
    parameter int N_MID    = 4,
    parameter int MULT_LAT = 5,
    parameter int SUM_LAT  = 14,
    parameter int IW       = (N_MID > 1) ? $clog2(N_MID) : 1
) (
    input  logic          iCLK,
    input  logic          iRST_N,
    input  logic          iSTART,
    output logic          oBUSY,
    output logic          oX_LOAD,
    output logic          oW_REN,
    output logic [IW-1:0] oW_RADDR,
    input  logic [31:0]   iSUM,
    output logic          oRES_WE,
    output logic [IW-1:0] oRES_ADDR,
    output logic [31:0]   oRES_DATA,
    output logic          oDONE
);
    localparam int PIPE_LAT = 1 + MULT_LAT + SUM_LAT;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t              state_q, state_d;
    logic [IW-1:0]       cnt_q, cnt_d;
    logic [PIPE_LAT-1:0] vld_q;
    logic [IW-1:0]       idx_q [PIPE_LAT];
    logic                res_we_q;
    logic [IW-1:0]       res_addr_q;
    logic [31:0]         res_data_q;
    logic                last_wr;
    assign last_wr   = res_we_q && (res_addr_q == IW'(N_MID - 1));
    assign oBUSY     = state_q != IDLE;
    assign oX_LOAD   = (state_q == IDLE) && iSTART;
    assign oW_REN    = state_q == ISSUE;
    assign oW_RADDR  = oW_REN ? cnt_q : '0;
    assign oRES_WE   = res_we_q;
    assign oRES_ADDR = res_addr_q;
    assign oRES_DATA = res_data_q;
    assign oDONE     = state_q == DONE;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (iSTART) begin
                    state_d = ISSUE;
                    cnt_d   = '0;
                end
            end
            ISSUE: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == IW'(N_MID - 1)) ? DRAIN : ISSUE;
            end
            DRAIN:   state_d = last_wr ? DONE : DRAIN;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    // Tagged valid delay line matching the datapath latency; the tail lines up with iSUM.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            vld_q <= '0;
            for (int k = 0; k < PIPE_LAT; k++) idx_q[k] <= '0;
        end else begin
            vld_q[0] <= oW_REN;
            idx_q[0] <= oW_RADDR;
            for (int k = 1; k < PIPE_LAT; k++) begin
                vld_q[k] <= vld_q[k-1];
                idx_q[k] <= idx_q[k-1];
            end
        end
    end
    // Register the result so the buffer sees a clean write one cycle after iSUM is valid.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            res_we_q   <= 1'b0;
            res_addr_q <= '0;
            res_data_q <= '0;
        end else begin
            res_we_q <= vld_q[PIPE_LAT-1];
            if (vld_q[PIPE_LAT-1]) begin
                res_addr_q <= idx_q[PIPE_LAT-1];
                res_data_q <= iSUM;
            end
        end
    end
endmodule
